// File: rtl/fact_pkg.sv
// Shared types and constants for the iterative factorial engine.
package fact_pkg;

  localparam int WIDTH = 32;
  localparam int MAX_N = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fact_mul.sv
// Combinational WIDTH x NW multiplier returning the low WIDTH bits of the product.
module fact_mul #(
  parameter int WIDTH = 32,
  parameter int NW    = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [NW-1:0]    b,
  output logic [WIDTH-1:0] p
);

  logic [WIDTH-1:0] b_ext;

  always_comb begin
    b_ext = '0;
    b_ext[NW-1:0] = b;
    p = a * b_ext;
  end

endmodule

// File: rtl/fact_core.sv
// Iterative factorial engine: go/done handshake, down-counter and product register
// fed by a load/multiply select mux.
module fact_core #(
  parameter int WIDTH = fact_pkg::WIDTH,
  parameter int NW    = 4,
  parameter int MAX_N = fact_pkg::MAX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [NW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  import fact_pkg::*;

  state_t           state, state_n;
  logic [NW-1:0]    cnt;
  logic [WIDTH-1:0] prod, prod_d, mul_out;
  logic             go_q, go_rise;
  logic             load, mul_en, capture, reject;

  fact_mul #(.WIDTH(WIDTH), .NW(NW)) u_mul (
    .a(prod),
    .b(cnt),
    .p(mul_out)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    mul_en  = 1'b0;
    capture = 1'b0;
    reject  = 1'b0;
    go_rise = go & ~go_q;
    case (state)
      IDLE: begin
        if (go_rise) begin
          if (int'(n) > MAX_N) begin
            reject = 1'b1;
          end else begin
            load    = 1'b1;
            state_n = CALC;
          end
        end
      end
      CALC: begin
        if (cnt > NW'(1)) begin
          mul_en = 1'b1;
        end else begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    prod_d = load ? WIDTH'(1) : mul_out;
  end

  // busy is registered from the next state so it tracks (state == CALC) exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      go_q   <= 1'b0;
    end else begin
      state <= state_n;
      go_q  <= go;
      busy  <= (state_n == CALC);
      if (load) begin
        cnt  <= n;
        prod <= prod_d;
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (mul_en) begin
        prod <= prod_d;
        cnt  <= cnt - NW'(1);
      end
      if (reject) begin
        err  <= 1'b1;
        done <= 1'b0;
      end
      if (capture) begin
        result <= prod;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fact_core.sv
// Self-checking bench for fact_core: transaction-level timeline model plus directed runs.
module tb_fact_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic [3:0]  n   = '0;
  logic        busy, done, err;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  fact_core #(.WIDTH(32), .NW(4), .MAX_N(12)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  function automatic logic [31:0] fact_f(input int v);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 2; i <= v; i++) r = r * 64'(i);
    return r[31:0];
  endfunction

  // Model: an accepted operand occupies the engine for max(n,1) busy cycles,
  // then presents n! with done, then needs one more cycle before accepting again.
  int          m_phase = 0;
  int          m_left  = 0;
  bit          m_prev  = 1'b0;
  bit          m_busy  = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [31:0] m_result = '0, m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_left <= 0; m_prev <= 1'b0;
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_result <= '0;
    end else begin
      m_prev <= go;
      case (m_phase)
        0: if (go && !m_prev) begin
             if (int'(n) > 12) begin
               m_err <= 1'b1; m_done <= 1'b0;
             end else begin
               m_err <= 1'b0; m_done <= 1'b0; m_busy <= 1'b1;
               m_left <= (n == 0) ? 1 : int'(n);
               m_pend <= fact_f(int'(n));
               m_phase <= 1;
             end
           end
        1: if (m_left <= 1) begin
             m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pend; m_phase <= 2;
           end else m_left <= m_left - 1;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("result", result, m_result);
    end
  end

  task automatic pulse(input logic [3:0] v);
    @(negedge clk); go = 1'b1; n = v;
    @(negedge clk); go = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles and cycles to done.
  task automatic run(input logic [3:0] v, input logic [31:0] exp, input string tag);
    int cyc, nb, expc;
    pulse(v);
    nb = 0;
    expc = (v == 0) ? 1 : int'(v);
    for (cyc = 0; cyc < 40; cyc++) begin
      if (done) break;
      if (busy) nb++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(expc));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(expc));
    chk({tag, "_result"}, result, exp);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    run(4'd5, 32'd120, "n5");
    chk("model_n5", m_result, 32'd120);
    chk("n5_err", 32'(err), 32'd0);
    run(4'd0, 32'd1, "n0");
    run(4'd1, 32'd1, "n1");
    run(4'd12, 32'h1C8CFC00, "n12");
    chk("model_n12", m_result, 32'd479001600);

    pulse(4'd13);
    chk("n13_err", 32'(err), 32'd1);
    chk("n13_busy", 32'(busy), 32'd0);
    chk("n13_result_held", result, 32'd479001600);
    repeat (2) @(negedge clk);
    run(4'd3, 32'd6, "after_err");
    chk("after_err_clear", 32'(err), 32'd0);

    // go held high across a whole n=4 run
    @(negedge clk); go = 1'b1; n = 4'd4;
    repeat (10) @(negedge clk);
    chk("held_result", result, 32'd24);
    chk("held_no_restart", 32'(busy), 32'd0);
    go = 1'b0;
    repeat (2) @(negedge clk);

    // extra go pulse while in CALC must be ignored
    pulse(4'd6);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (8) @(negedge clk);
    chk("midcalc_result", result, 32'd720);
    chk("midcalc_idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // reset during CALC aborts with no done afterwards
    pulse(4'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    run(4'd3, 32'd6, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
